// File: rtl/rca_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one shared 32-bit ripple-carry core,
// one word per clock, least-significant word first, carry chained in a register.

module rca32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        ci_i,
    output logic [31:0] s_o,
    output logic        co_o
);
    logic c;

    always_comb begin
        c   = ci_i;
        s_o = '0;
        for (int i = 0; i < 32; i++) begin
            s_o[i] = a_i[i] ^ b_i[i] ^ c;
            c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
        co_o = c;
    end
endmodule

module rca_seq_ctrl #(
    parameter int WORDS = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              sub,
    input  logic              ci,
    input  logic [32*WORDS-1:0] a,
    input  logic [32*WORDS-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [32*WORDS-1:0] s,
    output logic              co,
    output logic              ovf,
    output logic [1:0]        dbg_state
);
    localparam int W     = 32 * WORDS;
    localparam int IDX_W = $clog2(WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             cy_q, cy_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, s_q, s_d;
    logic             co_q, co_d, ovf_q, ovf_d;

    logic [31:0] core_a, core_b, core_s;
    logic        core_co;

    assign core_a = a_q[idx_q*32 +: 32];
    assign core_b = b_q[idx_q*32 +: 32];

    rca32 u_rca32 (
        .a_i (core_a),
        .b_i (core_b),
        .ci_i(cy_q),
        .s_o (core_s),
        .co_o(core_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cy_d    = cy_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Subtract is a + ~b + 1; the operand is inverted once at capture.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    cy_d    = sub ? 1'b1 : ci;
                    idx_d   = '0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                s_d[idx_q*32 +: 32] = core_s;
                cy_d                = core_co;
                idx_d               = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(WORDS - 1)) begin
                    co_d    = core_co;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (core_s[31] != a_q[W-1]);
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cy_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cy_q    <= cy_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = (state_q == ST_ADD) || (state_q == ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign s         = s_q;
    assign co        = co_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl (WORDS=4): hand-computed results, latency,
// handshake and reset behaviour.

module tb_rca_seq_ctrl;
  localparam int W = 128;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         ci = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, co, ovf;
  logic [W-1:0] s;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  rca_seq_ctrl #(.WORDS(4)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .sub      (sub),
    .ci       (ci),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .s        (s),
    .co       (co),
    .ovf      (ovf),
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full operation: start sampled at the edge before the first busy cycle.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tsub, input logic tci, input logic [W-1:0] exp_s,
                        input logic exp_co, input logic exp_ovf);
    int lat;
    int busy_cyc;
    bit seen;
    @(negedge clock);
    a = ta; b = tb; sub = tsub; ci = tci; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    a = ~ta; b = ~tb; sub = ~tsub; ci = ~tci;
    busy_cyc = busy ? 1 : 0;
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      lat++;
      if (busy) busy_cyc++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, ".done_seen"}, W'(seen), W'(1));
    check({tag, ".latency"}, W'(lat), W'(4));
    check({tag, ".s"}, s, exp_s);
    check({tag, ".co"}, W'(co), W'(exp_co));
    check({tag, ".ovf"}, W'(ovf), W'(exp_ovf));
    @(negedge clock);
    check({tag, ".busy_cycles"}, W'(busy_cyc), W'(5));
    check({tag, ".done_cleared"}, W'({busy, done}), W'(0));
    check({tag, ".s_held"}, s, exp_s);
  endtask

  initial begin
    int ndone;
    int first_cyc;
    int last_cyc;
    bit spacing_ok;
    bit done_seen;

    // Reset with random inputs toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      sub = 1'($urandom_range(0, 1));
      ci = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
    end
    check("rst.busy", W'(busy), W'(0));
    check("rst.done", W'(done), W'(0));
    check("rst.s", s, W'(0));
    check("rst.co", W'(co), W'(0));
    check("rst.ovf", W'(ovf), W'(0));
    check("rst.state", W'(dbg_state), W'(0));
    @(negedge clock);
    start = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("idle.flags", W'({busy, done, co, ovf}), W'(0));
      check("idle.s", s, W'(0));
    end

    run_op("ripple", {W{1'b1}}, W'(0), 1'b0, 1'b1, W'(0), 1'b1, 1'b0);
    run_op("wordcarry", 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, W'(1), 1'b0, 1'b0,
           128'h0000_0000_0000_0001_0000_0000_0000_0000, 1'b0, 1'b0);
    run_op("add_ci", W'(32'h1234), W'(32'h4321), 1'b0, 1'b1, W'(32'h5556), 1'b0, 1'b0);
    run_op("sub_borrow", W'(5), W'(7), 1'b1, 1'b0,
           128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_op("add_ovf", 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, W'(1), 1'b0, 1'b0,
           128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1);
    run_op("sub_ovf", 128'h8000_0000_0000_0000_0000_0000_0000_0000, W'(1), 1'b1, 1'b1,
           128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // Start pulsed during ADD must be ignored
    @(negedge clock);
    a = W'(100); b = W'(23); sub = 1'b0; ci = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    a = {W{1'b1}}; b = {W{1'b1}}; sub = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (done) begin
        ndone++;
        check("hs.s", s, W'(123));
        check("hs.co_ovf", W'({co, ovf}), W'(0));
      end
    end
    check("hs.done_count", W'(ndone), W'(1));
    check("hs.s_held", s, W'(123));

    // Asynchronous reset while index=2
    @(negedge clock);
    a = {W{1'b1}}; b = {W{1'b1}}; sub = 1'b0; ci = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("midrst.pre_busy", W'(busy), W'(1));
    #2 reset_n = 1'b0;
    #1;
    check("midrst.flags", W'({busy, done, co, ovf}), W'(0));
    check("midrst.s", s, W'(0));
    check("midrst.state", W'(dbg_state), W'(0));
    done_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (done) done_seen = 1'b1;
    end
    check("midrst.no_done", W'(done_seen), W'(0));
    reset_n = 1'b1;
    run_op("post_rst", W'(32'hFFFF_FFFF), W'(32'h1), 1'b0, 1'b0, W'(64'h1_0000_0000), 1'b0, 1'b0);

    // Start held high: back-to-back operations every 6 cycles
    @(negedge clock);
    a = 128'hFFFF_FFFF_0000_0000_FFFF_FFFF_0000_0001;
    b = 128'h0000_0000_FFFF_FFFF_0000_0000_FFFF_FFFF;
    sub = 1'b0; ci = 1'b0; start = 1'b1;
    ndone = 0; first_cyc = -1; last_cyc = -1; spacing_ok = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clock);
      if (done) begin
        ndone++;
        if (first_cyc < 0) first_cyc = cyc;
        else if (cyc - last_cyc != 6) spacing_ok = 1'b0;
        last_cyc = cyc;
        check("held.s", s, W'(0));
        check("held.co_ovf", W'({co, ovf}), W'(2'b10));
      end
    end
    start = 1'b0;
    check("held.done_count", W'(ndone), W'(3));
    check("held.first_done", W'(first_cyc), W'(4));
    check("held.spacing", W'(spacing_ok), W'(1));
    done_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (!busy) begin
        done_seen = 1'b1;
        break;
      end
    end
    check("held.drain", W'(done_seen), W'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
